vblank_update_arbiter: RTL and testbench

- Shares the game-object update port among NREQ game-logic requesters, but only inside a vertical-blanking window.
- The window opens on the VGA driver's animation tick.
- Grants are round-robin. Each requester is served at most once per frame, and each grant is hold-limited so that no object update can run into active video.
- Sits between the VGA timing driver and the object/sprite state registers.

---
 rtl/vblank_update_arbiter.sv | 167 ++++++++++++++++
 tb/tb_vblank_update_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vblank_update_arbiter.sv
// Shares the object-update port among NREQ requesters inside a per-frame vblank window.
// Define ARB_FIXED_PRIORITY_EN to grant the lowest eligible index instead of round-robin.
module vblank_update_arbiter #(
  parameter int NREQ          = 4,
  parameter int WINDOW_CYCLES = 50000,
  parameter int MAX_HOLD      = 4096,
  parameter int CW            = 16
) (
  input  logic            real100clock,
  input  logic            resetN,
  input  logic            frameTick,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  output logic [NREQ-1:0] grant,
  output logic            windowOpen,
  output logic            frameDone,
  output logic [NREQ-1:0] missedMask,
  output logic            overrun
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ARB, GRANT, CLOSE} state_t;

  state_t          state, state_nxt;
  logic            frame_tick_q;
  logic            tick_rise, expiry, done_hit, hold_limit, release_grant;
  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic [NREQ-1:0] eligible, served, served_nxt, grant_nxt, missed_nxt;
  logic [CW-1:0]   win_cnt, win_cnt_nxt, hold_cnt, hold_cnt_nxt;
  logic            window_nxt, overrun_nxt;

  assign tick_rise     = frameTick & ~frame_tick_q;
  assign expiry        = windowOpen && (win_cnt == CW'(1));
  assign eligible      = req & ~served;
  assign done_hit      = |(done & grant);
  assign hold_limit    = (hold_cnt == CW'(MAX_HOLD - 1));
  assign release_grant = (state == GRANT) && !expiry && (done_hit || hold_limit);
  assign frameDone     = (state == CLOSE);

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'(i);
      end
    end
  end
`else
  logic [PW-1:0] rr_ptr, rr_after, hi_idx, lo_idx;
  logic          hi_valid, lo_valid;

  // Lowest eligible index at/after the pointer wins; otherwise wrap to the lowest below it.
  always_comb begin
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        if (i >= int'(rr_ptr)) begin
          hi_valid = 1'b1;
          hi_idx   = PW'(i);
        end else begin
          lo_valid = 1'b1;
          lo_idx   = PW'(i);
        end
      end
    end
    pick_valid = hi_valid | lo_valid;
    pick_idx   = hi_valid ? hi_idx : lo_idx;
  end

  always_comb begin
    rr_after = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) rr_after = (i == NREQ - 1) ? '0 : PW'(i + 1);
    end
  end

  always_ff @(posedge real100clock or negedge resetN) begin
    if (!resetN)            rr_ptr <= '0;
    else if (release_grant) rr_ptr <= rr_after;
  end
`endif

  always_ff @(posedge real100clock or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      frame_tick_q <= 1'b1;
      win_cnt      <= '0;
      hold_cnt     <= '0;
      served       <= '0;
      grant        <= '0;
      windowOpen   <= 1'b0;
      missedMask   <= '0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_nxt;
      frame_tick_q <= frameTick;
      win_cnt      <= win_cnt_nxt;
      hold_cnt     <= hold_cnt_nxt;
      served       <= served_nxt;
      grant        <= grant_nxt;
      windowOpen   <= window_nxt;
      missedMask   <= missed_nxt;
      overrun      <= overrun_nxt;
    end
  end

  // Window expiry overrides every state so no update can spill into active video.
  always_comb begin
    state_nxt    = state;
    win_cnt_nxt  = windowOpen ? (win_cnt - CW'(1)) : win_cnt;
    hold_cnt_nxt = hold_cnt;
    served_nxt   = served;
    grant_nxt    = grant;
    window_nxt   = windowOpen;
    missed_nxt   = missedMask;
    overrun_nxt  = overrun;
    if (expiry) begin
      grant_nxt  = '0;
      window_nxt = 1'b0;
      state_nxt  = CLOSE;
    end else begin
      case (state)
        IDLE: begin
          if (tick_rise) begin
            win_cnt_nxt = CW'(WINDOW_CYCLES);
            served_nxt  = '0;
            window_nxt  = 1'b1;
            state_nxt   = ARB;
          end
        end
        ARB: begin
          if (pick_valid) begin
            grant_nxt    = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
            hold_cnt_nxt = '0;
            state_nxt    = GRANT;
          end else if (&served) begin
            window_nxt = 1'b0;
            state_nxt  = CLOSE;
          end
        end
        GRANT: begin
          hold_cnt_nxt = hold_cnt + CW'(1);
          if (release_grant) begin
            served_nxt = served | grant;
            grant_nxt  = '0;
            state_nxt  = ARB;
            if (!done_hit) overrun_nxt = 1'b1;
          end
        end
        CLOSE: begin
          missed_nxt = req & ~served;
          state_nxt  = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vblank_update_arbiter.sv
// Scoreboard bench for vblank_update_arbiter (WINDOW_CYCLES=40, MAX_HOLD=16, NREQ=4).
module tb_vblank_update_arbiter;

  localparam int NEVER = 1000;
`ifdef ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct packed {
    logic       is_frame;
    logic [3:0] val;
    logic       ovr;
  } exp_t;

  logic       real100clock, resetN, frameTick;
  logic [3:0] req, resp_done, stray_done, done;
  logic [3:0] grant, missedMask;
  logic       windowOpen, frameDone, overrun;

  exp_t       expq[$];
  exp_t       pend;
  logic       close_pending;
  logic [3:0] prev_grant;
  int         checks = 0;
  int         failures = 0;
  int         delay[4];
  int         hold_seen = 0;
  int         cnt, hold;
  bit         seen;

  assign done = resp_done | stray_done;

  vblank_update_arbiter #(
    .NREQ(4), .WINDOW_CYCLES(40), .MAX_HOLD(16), .CW(16)
  ) dut (
    .real100clock(real100clock),
    .resetN(resetN),
    .frameTick(frameTick),
    .req(req),
    .done(done),
    .grant(grant),
    .windowOpen(windowOpen),
    .frameDone(frameDone),
    .missedMask(missedMask),
    .overrun(overrun)
  );

  initial real100clock = 1'b0;
  always #5 real100clock = ~real100clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  function automatic void pushGrant(input logic [3:0] g);
    expq.push_back('{is_frame: 1'b0, val: g, ovr: 1'b0});
  endfunction

  function automatic void pushFrame(input logic [3:0] missed, input logic ovr);
    expq.push_back('{is_frame: 1'b1, val: missed, ovr: ovr});
  endfunction

  task automatic applyStimulus(input logic [3:0] r, input int d);
    req = r;
    for (int i = 0; i < 4; i++) delay[i] = d;
  endtask

  task automatic openWindow(output int c);
    frameTick = 1'b0;
    @(negedge real100clock);
    frameTick = 1'b1;
    @(negedge real100clock);
    checkOutput("window_open_latency", windowOpen, 1);
    frameTick = 1'b0;
    c = 1;
  endtask

  task automatic waitFrameDone(input int init, output int c);
    bit found;
    found = 1'b0;
    c = init;
    for (int k = 0; k < 200; k++) begin
      @(negedge real100clock);
      if (frameDone) begin
        found = 1'b1;
        break;
      end
      if (windowOpen) c++;
    end
    if (!found) checkOutput("frame_done_timeout", 0, 1);
  endtask

  task automatic settle();
    repeat (2) @(negedge real100clock);
  endtask

  // Model requester: pulses done a programmed number of cycles after its grant appears.
  always @(negedge real100clock) begin
    resp_done = 4'b0000;
    if (grant == 4'b0000) hold_seen = 0;
    else begin
      hold_seen++;
      for (int i = 0; i < 4; i++)
        if (grant[i] && hold_seen == delay[i] + 1) resp_done[i] = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each new grant and each frameDone pulse.
  always @(negedge real100clock) begin
    if (resetN) begin
      checkOutput("grant_outside_window", {31'b0, (grant != 4'b0000) && !windowOpen}, 0);
      if (close_pending) begin
        checkOutput("missed_mask", missedMask, pend.val);
        checkOutput("overrun_at_close", overrun, pend.ovr);
        close_pending = 1'b0;
      end
      if (grant != 4'b0000 && prev_grant == 4'b0000) begin
        if (expq.size() == 0) checkOutput("unexpected_grant", grant, 0);
        else begin
          exp_t item;
          item = expq.pop_front();
          checkOutput("grant_order", {item.is_frame, grant}, {1'b0, item.val});
        end
      end
      if (frameDone) begin
        if (expq.size() == 0) checkOutput("unexpected_frame_done", frameDone, 0);
        else begin
          pend = expq.pop_front();
          checkOutput("frame_done_event", pend.is_frame, 1);
          close_pending = 1'b1;
        end
      end
      prev_grant = grant;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    close_pending = 1'b0;
    prev_grant    = 4'b0000;
    resp_done     = 4'b0000;
    stray_done    = 4'b0000;
    resetN        = 1'b0;
    frameTick     = 1'b1;
    applyStimulus(4'b0000, NEVER);

    @(negedge real100clock);
    checkOutput("reset_grant", grant, 0);
    checkOutput("reset_window_open", windowOpen, 0);
    checkOutput("reset_frame_done", frameDone, 0);
    checkOutput("reset_missed_mask", missedMask, 0);
    checkOutput("reset_overrun", overrun, 0);
    resetN = 1'b1;
    repeat (5) begin
      @(negedge real100clock);
      checkOutput("tick_high_at_reset_release", windowOpen, 0);
    end

    $display("[TB] frame 1: single requester, latency and full window length");
    applyStimulus(4'b0001, 3);
    pushGrant(4'b0001);
    pushFrame(4'b0000, 1'b0);
    openWindow(cnt);
    checkOutput("no_grant_at_open", grant, 0);
    @(negedge real100clock);
    checkOutput("first_grant_latency", grant, 4'b0001);
    if (windowOpen) cnt++;
    waitFrameDone(cnt, cnt);
    checkOutput("window_length_f1", cnt, 40);
    settle();

    $display("[TB] frame 2: all four requesters");
    applyStimulus(4'b1111, 3);
    if (FIXED) begin
      pushGrant(4'b0001); pushGrant(4'b0010); pushGrant(4'b0100); pushGrant(4'b1000);
    end else begin
      pushGrant(4'b0010); pushGrant(4'b0100); pushGrant(4'b1000); pushGrant(4'b0001);
    end
    pushFrame(4'b0000, 1'b0);
    openWindow(cnt);
    waitFrameDone(cnt, cnt);
    checkOutput("early_close_length", cnt, 21);
    settle();

    $display("[TB] frame 3: sparse requests");
    applyStimulus(4'b1010, 3);
    pushGrant(4'b0010);
    pushGrant(4'b1000);
    pushFrame(4'b0000, 1'b0);
    openWindow(cnt);
    waitFrameDone(cnt, cnt);
    checkOutput("window_length_f3", cnt, 40);
    settle();

    $display("[TB] frame 4: hold limit revoke");
    applyStimulus(4'b0100, NEVER);
    pushGrant(4'b0100);
    pushFrame(4'b0000, 1'b1);
    openWindow(cnt);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge real100clock);
      if (grant != 4'b0000) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("hold_grant_seen", seen, 1);
    hold = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge real100clock);
      if (grant != 4'b0000) hold++;
      else break;
    end
    checkOutput("hold_limit_cycles", hold, 16);
    checkOutput("overrun_set", overrun, 1);
    waitFrameDone(0, cnt);
    settle();

    $display("[TB] frame 5: pointer after revoke");
    applyStimulus(4'b1001, 3);
    if (FIXED) begin
      pushGrant(4'b0001); pushGrant(4'b1000);
    end else begin
      pushGrant(4'b1000); pushGrant(4'b0001);
    end
    pushFrame(4'b0000, 1'b1);
    openWindow(cnt);
    waitFrameDone(cnt, cnt);
    checkOutput("window_length_f5", cnt, 40);
    settle();

    $display("[TB] frame 6: expiry during a grant");
    applyStimulus(4'b0000, NEVER);
    pushGrant(4'b0001);
    pushFrame(4'b0001, 1'b1);
    openWindow(cnt);
    repeat (28) begin
      @(negedge real100clock);
      if (windowOpen) cnt++;
    end
    req = 4'b0001;
    waitFrameDone(cnt, cnt);
    checkOutput("window_length_f6", cnt, 40);
    checkOutput("grant_cleared_at_expiry", grant, 0);
    @(negedge real100clock);
    req = 4'b0000;
    @(negedge real100clock);

    $display("[TB] frame 7: stray done and tick while open");
    applyStimulus(4'b0010, 10);
    pushGrant(4'b0010);
    pushFrame(4'b0000, 1'b1);
    openWindow(cnt);
    @(negedge real100clock);
    if (windowOpen) cnt++;
    @(negedge real100clock);
    if (windowOpen) cnt++;
    stray_done = 4'b0001;
    frameTick  = 1'b1;
    @(negedge real100clock);
    if (windowOpen) cnt++;
    stray_done = 4'b0000;
    frameTick  = 1'b0;
    checkOutput("stray_done_ignored", grant, 4'b0010);
    checkOutput("tick_in_window_ignored", windowOpen, 1);
    waitFrameDone(cnt, cnt);
    checkOutput("window_length_f7", cnt, 40);
    settle();

    checkOutput("scoreboard_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
